// File: rtl/dmem_access_unit.sv
// Data-memory access unit: byte-lane loads with sign/zero extension, read-modify-write
// sub-word stores, alignment/funct3 checking and a bounded request/acknowledge handshake.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {StIdle, StAccess, StRd, StGap, StWr, StResp} state_e;

    state_e      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [7:0]  cnt_q;
    logic        mem_req_q, mem_we_q;
    logic [29:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic [1:0]  resp_err_q;

    logic        f3_legal, misaligned, rmw, timeout_hit;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data, merge_word;

    always_comb begin
        if (req_we) f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                               (req_funct3 == 3'b010);
        else        f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                               (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                               (req_funct3 == 3'b101);
    end

    assign misaligned  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign rmw         = req_we && (req_funct3[1:0] != 2'b10);
    assign timeout_hit = ({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT_CYCLES);

    assign byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    assign half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        merge_word = mem_rdata;
        if (funct3_q[1:0] == 2'b00) merge_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else                        merge_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            wdata_q      <= 32'd0;
            cnt_q        <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 30'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 2'b00;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        funct3_q   <= req_funct3;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        mem_addr_q <= req_addr[31:2];
                        cnt_q      <= 8'd0;
                        if (!f3_legal || misaligned) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= !f3_legal ? 2'b10 : 2'b01;
                            resp_rdata_q <= 32'd0;
                            state_q      <= StResp;
                        end else begin
                            mem_req_q <= 1'b1;
                            mem_we_q  <= req_we && !rmw;
                            if (req_we) mem_wdata_q <= req_wdata;
                            state_q   <= rmw ? StRd : StAccess;
                        end
                    end
                end
                StAccess, StRd, StWr: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (state_q == StRd) begin
                            mem_wdata_q <= merge_word;
                            state_q     <= StGap;
                        end else begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 2'b00;
                            resp_rdata_q <= we_q ? 32'd0 : load_data;
                            state_q      <= StResp;
                        end
                    end else if (timeout_hit) begin
                        // Abort: any ack arriving later lands in RESP/IDLE and is ignored.
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 2'b11;
                        resp_rdata_q <= 32'd0;
                        state_q      <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StGap: begin
                    mem_req_q <= 1'b1;
                    mem_we_q  <= 1'b1;
                    cnt_q     <= 8'd0;
                    state_q   <= StWr;
                end
                StResp: begin
                    resp_err_q   <= 2'b00;
                    resp_rdata_q <= 32'd0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: vector table plus timeout, back-pressure and
// reset-during-write sequences against a small behavioural RAM with configurable wait states.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    dmem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: acks after wait_cycles request cycles, driven on the falling edge.
    logic [31:0] ram [0:255];
    int          wait_cycles = 0;
    int          wcnt = 0;
    logic        ack_en = 1'b1;
    logic        force_ack = 1'b0;

    always @(negedge clk) begin
        if (force_ack) begin
            mem_ack = 1'b1;
        end else if (mem_req && ack_en) begin
            if (wcnt == wait_cycles) begin
                mem_ack   = 1'b1;
                mem_rdata = ram[mem_addr[7:0]];
                if (mem_we) ram[mem_addr[7:0]] = mem_wdata;
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one access; returns latency from the accept edge and the {mem_req,mem_we}
    // pattern seen in each cycle up to and including the response cycle.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat,
                           output logic [31:0] rdata, output logic [1:0] err,
                           output logic [15:0] pat);
        int guard = 0;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        step();
        req_valid = 1'b0;
        lat   = 0;
        rdata = 32'hxxxxxxxx;
        err   = 2'bxx;
        pat   = 16'd0;
        for (int i = 1; i <= 100; i++) begin
            pat = {pat[13:0], mem_req, mem_we};
            if (resp_valid) begin
                lat   = i;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
            step();
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
        int          exp_lat;
        logic [15:0] exp_pat;
        logic [31:0] exp_ram;
    } vec_t;

    vec_t vecs[20];

    int          lat;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [15:0] pat;

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 32'h102, 32'h0,        32'hFFFFFF99, 2'b00, 2, 16'h0008, 32'h8899AABB};
        vecs[1]  = '{1'b0, 3'b100, 32'h102, 32'h0,        32'h00000099, 2'b00, 2, 16'h0008, 32'h8899AABB};
        vecs[2]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h00008899, 2'b00, 2, 16'h0008, 32'h8899AABB};
        vecs[3]  = '{1'b0, 3'b001, 32'h100, 32'h0,        32'hFFFFAABB, 2'b00, 2, 16'h0008, 32'h8899AABB};
        vecs[4]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8899AABB, 2'b00, 2, 16'h0008, 32'h8899AABB};
        vecs[5]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFFFFAA, 2'b00, 2, 16'h0008, 32'h8899AABB};
        vecs[6]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h00000088, 2'b00, 2, 16'h0008, 32'h8899AABB};
        vecs[7]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFF8899, 2'b00, 2, 16'h0008, 32'h8899AABB};
        vecs[8]  = '{1'b1, 3'b000, 32'h101, 32'h12345677, 32'h0,        2'b00, 4, 16'h008C, 32'h889977BB};
        vecs[9]  = '{1'b1, 3'b001, 32'h102, 32'h0000CAFE, 32'h0,        2'b00, 4, 16'h008C, 32'hCAFEAABB};
        vecs[10] = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        2'b00, 2, 16'h000C, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        2'b00, 4, 16'h008C, 32'hA599AABB};
        vecs[12] = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        2'b01, 1, 16'h0000, 32'h8899AABB};
        vecs[13] = '{1'b1, 3'b001, 32'h101, 32'h0,        32'h0,        2'b01, 1, 16'h0000, 32'h8899AABB};
        vecs[14] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        2'b10, 1, 16'h0000, 32'h8899AABB};
        vecs[15] = '{1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        2'b10, 1, 16'h0000, 32'h8899AABB};
        vecs[16] = '{1'b1, 3'b011, 32'h101, 32'h0,        32'h0,        2'b10, 1, 16'h0000, 32'h8899AABB};
        vecs[17] = '{1'b0, 3'b001, 32'h103, 32'h0,        32'h0,        2'b01, 1, 16'h0000, 32'h8899AABB};
        vecs[18] = '{1'b0, 3'b110, 32'h101, 32'h0,        32'h0,        2'b10, 1, 16'h0000, 32'h8899AABB};
        vecs[19] = '{1'b1, 3'b000, 32'h100, 32'h000000FF, 32'h0,        2'b00, 4, 16'h008C, 32'h8899AAFF};

        for (int i = 0; i < 256; i++) ram[i] = 32'h0;

        // Reset values
        step();
        step();
        chk("rst req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_err",   {30'd0, resp_err},   32'd0);
        chk("rst resp_rdata", resp_rdata,          32'd0);
        chk("rst mem_req",    {31'd0, mem_req},    32'd0);
        chk("rst mem_we",     {31'd0, mem_we},     32'd0);
        chk("rst mem_addr",   {2'd0, mem_addr},    32'd0);
        chk("rst mem_wdata",  mem_wdata,           32'd0);
        rst = 1'b0;
        step();

        // Vector table, zero-wait RAM
        for (int i = 0; i < 20; i++) begin
            ram[8'h40] = 32'h8899AABB;
            run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rdata, err, pat);
            chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d err", i), {30'd0, err}, {30'd0, vecs[i].exp_err});
            chk($sformatf("v%0d mem pattern", i), {16'd0, pat}, {16'd0, vecs[i].exp_pat});
            chk($sformatf("v%0d ram word", i), ram[8'h40], vecs[i].exp_ram);
            step();
        end

        // Timeout with ack held low, then a late ack that must be ignored
        ram[8'h40] = 32'h8899AABB;
        ack_en = 1'b0;
        run_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rdata, err, pat);
        chk("timeout latency", lat, 5);
        chk("timeout err", {30'd0, err}, 32'd3);
        chk("timeout rdata", rdata, 32'd0);
        chk("timeout mem pattern", {16'd0, pat}, 32'h2A8);
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("late ack quiet %0d", i), {30'd0, resp_valid, mem_req}, 32'd0);
        end
        force_ack = 1'b0;
        ack_en = 1'b1;
        chk("late ack ready", {31'd0, req_ready}, 32'd1);
        run_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rdata, err, pat);
        chk("post-timeout LW rdata", rdata, 32'h8899AABB);
        chk("post-timeout LW latency", lat, 2);
        step();

        // Three wait states, req_valid held high across two back-to-back LWs
        begin
            logic [11:0] ready_pat = 12'd0;
            int          nresp = 0;
            wait_cycles = 3;
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = 3'b010;
            req_addr   = 32'h100;
            for (int i = 0; i < 12; i++) begin
                step();
                ready_pat = {ready_pat[10:0], req_ready};
                if (resp_valid) begin
                    nresp++;
                    chk($sformatf("wait3 rdata %0d", nresp), resp_rdata, 32'h8899AABB);
                end
            end
            req_valid = 1'b0;
            chk("wait3 ready pattern", {20'd0, ready_pat}, 32'b000001000001);
            chk("wait3 response count", nresp, 2);
            wait_cycles = 0;
            step();
            step();
        end

        // Reset while an SH is in its write phase
        begin
            logic found = 1'b0;
            int   nresp = 0;
            ram[8'h40] = 32'h8899AABB;
            wait_cycles = 2;
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'b001;
            req_addr   = 32'h100;
            req_wdata  = 32'h00001111;
            step();
            req_valid = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (mem_req && mem_we) found = 1'b1;
                else step();
            end
            chk("rst-in-wr reached WR", {31'd0, found}, 32'd1);
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("rst-in-wr mem_req", {31'd0, mem_req}, 32'd0);
            chk("rst-in-wr req_ready", {31'd0, req_ready}, 32'd1);
            chk("rst-in-wr resp_valid", {31'd0, resp_valid}, 32'd0);
            for (int i = 0; i < 6; i++) begin
                step();
                if (resp_valid) nresp++;
            end
            chk("rst-in-wr no response", nresp, 0);
            chk("rst-in-wr ram untouched", ram[8'h40], 32'h8899AABB);
            wait_cycles = 0;
            run_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rdata, err, pat);
            chk("after-rst LW rdata", rdata, 32'h8899AABB);
            chk("after-rst LW err", {30'd0, err}, 32'd0);
            chk("after-rst LW latency", lat, 2);
        end

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
